// File: rtl/dmem_boot_loader_pkg.sv
// dmem_boot_loader_pkg
// Definitions shared by the data-memory boot loader and its byte packer.
//   - state_t    : loader FSM encoding (also exported on the debug port)
//   - WORD_BYTES : bytes per 32-bit word. The length header and the checksum
//                  trailer are also one word each.
// Endianness: the stream is big-endian. The first byte of a word lands in
// bits 31:24 and the fourth byte lands in bits 7:0.
package dmem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_SUM  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  // The states in which the loader consumes stream bytes.
  function automatic logic state_is_busy(input state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_SUM);
  endfunction

endpackage

// File: rtl/dmem_boot_loader_if.sv
// dmem_boot_loader_if
// Byte-stream link from the host or flash reader into the boot loader.
//   in_data  : stream byte, driven by the master
//   in_valid : in_data is valid, driven by the master
//   in_ready : the loader can accept a byte this cycle, driven by the slave
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both 1. in_ready does not depend on in_valid. While in_valid
// is high, in_data must stay stable until the byte is transferred.
interface dmem_boot_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/dmem_boot_loader_byte_word_packer.sv
// byte_word_packer
// Packs accepted stream bytes into big-endian 32-bit words.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   byte_in       : stream byte
//   accept        : byte_in is consumed on this edge
//   clear         : discards any partial word (has priority over accept)
//   word_complete : combinational pulse; the current accept is the 4th byte
//   word          : assembled word, valid while word_complete is 1
// The fourth byte is not stored. The word is formed combinationally from the
// three buffered bytes and the live byte. The owner registers the result, so
// the packer can start the next word on the following cycle.
module byte_word_packer
  import dmem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        accept,
  input  logic        clear,
  output logic        word_complete,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (accept) begin
      sr_d  = {sr_q[15:0], byte_in};
      // The counter wraps 3 -> 0 when a word completes.
      cnt_d = cnt_q + 2'd1;
    end
  end

  assign word_complete = accept && !clear && (cnt_q == 2'(WORD_BYTES - 1));
  assign word          = {sr_q, byte_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/dmem_boot_loader.sv
// dmem_boot_loader
// Streams a data image into data memory through its boot port. It checks an
// XOR checksum and holds the core in reset until a verified load completes.
// Stream layout, big-endian: length N (words), then N data words, then a
// checksum word equal to the XOR of all data words.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   start        : one-cycle pulse; starts a load from IDLE, DONE or ERR
//   s_in         : byte stream (slave side of dmem_boot_loader_if)
//   boot_daddr   : word index of the write, zero-extended to 32 bits
//   boot_ddata   : data of the write
//   boot_dwe     : one-cycle write strobe; address and data are stable with it
//   cpu_resetn   : active-low core reset; high only in DONE
//   busy         : a load is in progress (HDR, DATA or SUM)
//   done / error : load verified / length or checksum failure
//   dbg_state    : current FSM state
module dmem_boot_loader
  import dmem_boot_loader_pkg::*;
#(
  parameter int DM_ADDRESSWIDTH = 16,
  parameter int DM_SIZE         = 16384
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  dmem_boot_loader_if.slave    s_in,
  output logic [31:0]          boot_daddr,
  output logic [31:0]          boot_ddata,
  output logic                 boot_dwe,
  output logic                 cpu_resetn,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output state_t               dbg_state
);

  localparam int IW = DM_ADDRESSWIDTH - 2;

  state_t          state_q, state_d;
  logic [31:0]     len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     csum_q, csum_d;
  logic [IW-1:0]   daddr_q, daddr_d;
  logic [31:0]     ddata_q, ddata_d;
  logic            dwe_q, dwe_d;

  logic            busy_w;
  logic            accept;
  logic            pk_clear;
  logic            word_complete;
  logic [31:0]     word;

  assign busy_w = state_is_busy(state_q);
  assign accept = s_in.in_valid && busy_w;

  byte_word_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .byte_in       (s_in.in_data),
    .accept        (accept),
    .clear         (pk_clear),
    .word_complete (word_complete),
    .word          (word)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    daddr_d  = daddr_q;
    ddata_d  = ddata_q;
    dwe_d    = 1'b0;
    pk_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_HDR;
          idx_d    = '0;
          csum_d   = '0;
          pk_clear = 1'b1;
        end
      end

      ST_HDR: begin
        if (word_complete) begin
          len_d = word;
          // Oversized images are rejected here. This check keeps the word
          // index inside IW bits for the rest of the load.
          if (word > 32'(DM_SIZE)) begin
            state_d = ST_ERR;
          end else if (word == 32'd0) begin
            state_d = ST_SUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (word_complete) begin
          daddr_d = idx_q;
          ddata_d = word;
          dwe_d   = 1'b1;
          csum_d  = csum_q ^ word;
          idx_d   = idx_q + 1'b1;
          // len_q is at least 1 in this state, so len_q - 1 cannot underflow.
          if (32'(idx_q) == (len_q - 32'd1)) begin
            state_d = ST_SUM;
          end
        end
      end

      ST_SUM: begin
        if (word_complete) begin
          state_d = (word == csum_q) ? ST_DONE : ST_ERR;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      daddr_q <= '0;
      ddata_q <= '0;
      dwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
      dwe_q   <= dwe_d;
    end
  end

  // Status outputs are decoded from the registered state only.
  assign s_in.in_ready = busy_w;
  assign busy          = busy_w;
  assign done          = (state_q == ST_DONE);
  assign error         = (state_q == ST_ERR);
  assign cpu_resetn    = (state_q == ST_DONE);
  assign boot_daddr    = 32'(daddr_q);
  assign boot_ddata    = ddata_q;
  assign boot_dwe      = dwe_q;
  assign dbg_state     = state_q;

endmodule
